// File: rtl/fetch_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_stage : instruction fetch with IF/ID register, stall hold and redirect
// rev 1.0
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stallI,
  input  logic        branchTakenI,
  input  logic [31:0] branchTargetI,
  input  logic        jumpI,
  input  logic [31:0] jumpTargetI,
  output logic        imemReqO,
  output logic [31:0] imemAddrO,
  input  logic        imemReadyI,
  input  logic [31:0] imemDataI,
  output logic [31:0] instruccionO,
  output logic [31:0] instruccionSiguienteO,
  output logic        validO
);

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] next_q, next_d;
  logic        valid_q, valid_d;
  logic [31:0] hold_word_q, hold_word_d;
  logic [31:0] hold_next_q, hold_next_d;

  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] pc_plus4;

  // Branch wins over jump when both are raised in the same cycle.
  assign redirect        = branchTakenI | jumpI;
  assign redirect_target = branchTakenI ? branchTargetI : jumpTargetI;
  assign pc_plus4        = pc_q + 32'd4;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    next_d      = next_q;
    valid_d     = valid_q;
    hold_word_d = hold_word_q;
    hold_next_d = hold_next_q;

    if (redirect) begin
      pc_d        = redirect_target & 32'hFFFF_FFFC;
      instr_d     = 32'h0;
      next_d      = 32'h0;
      valid_d     = 1'b0;
      hold_word_d = 32'h0;
      hold_next_d = 32'h0;
      state_d     = FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (imemReadyI && !stallI) begin
            instr_d = imemDataI;
            next_d  = pc_plus4;
            valid_d = 1'b1;
            pc_d    = pc_plus4;
          end else if (imemReadyI && stallI) begin
            // Decode is frozen: park the word until the stall clears.
            hold_word_d = imemDataI;
            hold_next_d = pc_plus4;
            state_d     = HOLD;
          end else if (!stallI) begin
            instr_d = 32'h0;
            valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stallI) begin
            instr_d = hold_word_q;
            next_d  = hold_next_q;
            valid_d = 1'b1;
            pc_d    = pc_plus4;
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      instr_q     <= 32'h0;
      next_q      <= 32'h0;
      valid_q     <= 1'b0;
      hold_word_q <= 32'h0;
      hold_next_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      next_q      <= next_d;
      valid_q     <= valid_d;
      hold_word_q <= hold_word_d;
      hold_next_q <= hold_next_d;
    end
  end

  assign imemReqO              = rst_n && (state_q == FETCH);
  assign imemAddrO             = pc_q;
  assign instruccionO          = instr_q;
  assign instruccionSiguienteO = next_q;
  assign validO                = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fetch_stage : directed scenarios plus random traffic against a model
// rev 1.0
// ---------------------------------------------------------------------------
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stallI = 1'b0;
  logic        branchTakenI = 1'b0;
  logic [31:0] branchTargetI = 32'h0;
  logic        jumpI = 1'b0;
  logic [31:0] jumpTargetI = 32'h0;
  logic        imemReqO;
  logic [31:0] imemAddrO;
  logic        imemReadyI = 1'b0;
  logic [31:0] imemDataI = 32'h0;
  logic [31:0] instruccionO;
  logic [31:0] instruccionSiguienteO;
  logic        validO;

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .stallI                (stallI),
    .branchTakenI          (branchTakenI),
    .branchTargetI         (branchTargetI),
    .jumpI                 (jumpI),
    .jumpTargetI           (jumpTargetI),
    .imemReqO              (imemReqO),
    .imemAddrO             (imemAddrO),
    .imemReadyI            (imemReadyI),
    .imemDataI             (imemDataI),
    .instruccionO          (instruccionO),
    .instruccionSiguienteO (instruccionSiguienteO),
    .validO                (validO)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference model: one pending-word slot while decode is stalled.
  logic [31:0] m_pc, m_instr, m_next, m_hword, m_hnext;
  logic        m_valid, m_held, m_next_known;
  logic        m_redir;
  logic [31:0] m_tgt;
  assign m_redir = branchTakenI | jumpI;
  assign m_tgt   = branchTakenI ? branchTargetI : jumpTargetI;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= RESET_PC; m_instr <= 32'h0; m_next <= 32'h0; m_valid <= 1'b0;
      m_held <= 1'b0; m_hword <= 32'h0; m_hnext <= 32'h0; m_next_known <= 1'b1;
    end else if (m_redir) begin
      m_pc <= {m_tgt[31:2], 2'b00}; m_instr <= 32'h0; m_next <= 32'h0;
      m_valid <= 1'b0; m_held <= 1'b0; m_next_known <= 1'b1;
    end else if (m_held) begin
      if (!stallI) begin
        m_instr <= m_hword; m_next <= m_hnext; m_valid <= 1'b1;
        m_pc <= m_pc + 32'd4; m_held <= 1'b0; m_next_known <= 1'b1;
      end
    end else if (imemReadyI) begin
      if (!stallI) begin
        m_instr <= imemDataI; m_next <= m_pc + 32'd4; m_valid <= 1'b1;
        m_pc <= m_pc + 32'd4; m_next_known <= 1'b1;
      end else begin
        m_hword <= imemDataI; m_hnext <= m_pc + 32'd4; m_held <= 1'b1;
      end
    end else if (!stallI) begin
      m_instr <= 32'h0; m_valid <= 1'b0; m_next_known <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("model_req",   {31'b0, imemReqO}, {31'b0, rst_n & ~m_held});
    chk("model_addr",  imemAddrO, m_pc);
    chk("model_instr", instruccionO, m_instr);
    chk("model_valid", {31'b0, validO}, {31'b0, m_valid});
    if (m_next_known) chk("model_next", instruccionSiguienteO, m_next);
  end

  // Apply one cycle of inputs and return at the following falling edge.
  task automatic cyc(input logic st, input logic rdy, input logic [31:0] d,
                     input logic br, input logic [31:0] bt,
                     input logic jp, input logic [31:0] jt);
    #1;
    stallI = st; imemReadyI = rdy; imemDataI = d;
    branchTakenI = br; branchTargetI = bt; jumpI = jp; jumpTargetI = jt;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_req",   {31'b0, imemReqO}, 32'h0);
    chk("rst_addr",  imemAddrO, 32'h0);
    chk("rst_valid", {31'b0, validO}, 32'h0);
    chk("rst_instr", instruccionO, 32'h0);
    #1 rst_n = 1'b1;

    // zero-wait stream
    cyc(0, 1, 32'h11, 0, 0, 0, 0);
    chk("s1_instr", instruccionO, 32'h11); chk("s1_next", instruccionSiguienteO, 32'h4);
    chk("s1_valid", {31'b0, validO}, 32'h1);
    cyc(0, 1, 32'h22, 0, 0, 0, 0);
    chk("s2_instr", instruccionO, 32'h22); chk("s2_next", instruccionSiguienteO, 32'h8);
    cyc(0, 1, 32'h33, 0, 0, 0, 0);
    chk("s3_instr", instruccionO, 32'h33); chk("s3_next", instruccionSiguienteO, 32'hC);

    // wait states at 0x8
    cyc(0, 0, 0, 0, 0, 1, 32'h8);
    chk("jmp_addr", imemAddrO, 32'h8);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("w1_addr", imemAddrO, 32'h8); chk("w1_valid", {31'b0, validO}, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("w2_addr", imemAddrO, 32'h8); chk("w2_valid", {31'b0, validO}, 32'h0);
    cyc(0, 1, 32'h44, 0, 0, 0, 0);
    chk("w3_instr", instruccionO, 32'h44); chk("w3_next", instruccionSiguienteO, 32'hC);
    cyc(0, 1, 32'h55, 0, 0, 0, 0);
    chk("w4_addr", imemAddrO, 32'h10);

    // stall on return at 0x10
    cyc(1, 1, 32'hAA, 0, 0, 0, 0);
    chk("h1_req", {31'b0, imemReqO}, 32'h0); chk("h1_instr", instruccionO, 32'h55);
    cyc(1, 1, 32'hBB, 0, 0, 0, 0);
    chk("h2_req", {31'b0, imemReqO}, 32'h0); chk("h2_instr", instruccionO, 32'h55);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("h3_instr", instruccionO, 32'hAA); chk("h3_valid", {31'b0, validO}, 32'h1);
    chk("h3_addr", imemAddrO, 32'h14); chk("h3_next", instruccionSiguienteO, 32'h14);

    // redirect over stall in HOLD
    cyc(1, 1, 32'hCC, 0, 0, 0, 0);
    chk("r1_req", {31'b0, imemReqO}, 32'h0);
    cyc(1, 0, 0, 1, 32'h102, 0, 0);
    chk("r2_addr", imemAddrO, 32'h100); chk("r2_valid", {31'b0, validO}, 32'h0);
    chk("r2_req", {31'b0, imemReqO}, 32'h1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("r3_instr", instruccionO, 32'h0); chk("r3_valid", {31'b0, validO}, 32'h0);

    // branch beats jump; PC+4 wraps
    cyc(0, 0, 0, 1, 32'h200, 1, 32'h300);
    chk("bj_addr", imemAddrO, 32'h200);
    cyc(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    chk("wr_addr", imemAddrO, 32'hFFFF_FFFC);
    cyc(0, 1, 32'h77, 0, 0, 0, 0);
    chk("wr_next", instruccionSiguienteO, 32'h0); chk("wr_addr2", imemAddrO, 32'h0);

    // async reset pulse during HOLD at 0x4
    cyc(0, 1, 32'h88, 0, 0, 0, 0);
    cyc(1, 1, 32'h99, 0, 0, 0, 0);
    chk("ar_hold_req", {31'b0, imemReqO}, 32'h0);
    #2 rst_n = 1'b0;
    stallI = 1'b0; imemReadyI = 1'b0;
    #1;
    chk("ar_instr", instruccionO, 32'h0); chk("ar_next", instruccionSiguienteO, 32'h0);
    chk("ar_valid", {31'b0, validO}, 32'h0); chk("ar_addr", imemAddrO, RESET_PC);
    chk("ar_req", {31'b0, imemReqO}, 32'h0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ar_bubble", {31'b0, validO}, 32'h0); chk("ar_req2", {31'b0, imemReqO}, 32'h1);
    cyc(0, 1, 32'h12, 0, 0, 0, 0);
    chk("ar_instr2", instruccionO, 32'h12); chk("ar_next2", instruccionSiguienteO, 32'h4);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [31:0] tb, tj;
      r  = $urandom_range(0, 99);
      tb = $urandom;
      tj = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      cyc($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 70, $urandom,
          (r < 4) || (r == 10), tb, (r >= 4 && r < 7) || (r == 10), tj);
      if ($urandom_range(0, 199) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
